// File: rtl/wr_fec_hamming_dec.sv
// rtl/wr_fec_hamming_dec.sv - SEC-DED Hamming(72,64) block decoder for the WR FEC receive path

module wr_fec_hamming_cw_dec (
    input  logic [71:0] cw,
    output logic [63:0] data,
    output logic        corr,
    output logic        err
);

    logic [6:0]  syn;
    logic        par;
    logic [63:0] raw;
    logic [63:0] flip;

    always_comb begin
        syn = '0;
        par = cw[0];
        for (int i = 1; i < 72; i++) begin
            if (cw[i]) begin
                syn = syn ^ 7'(i);
            end
            par = par ^ cw[i];
        end
    end

    // Data bits live at non-power-of-two positions; the flip mask marks the one the syndrome points at.
    always_comb begin
        int k;
        raw  = '0;
        flip = '0;
        k    = 0;
        for (int i = 1; i < 72; i++) begin
            if ((i & (i - 1)) != 0) begin
                raw[k]  = cw[i];
                flip[k] = (syn == 7'(i));
                k       = k + 1;
            end
        end
    end

    always_comb begin
        corr = par && (syn <= 7'd71);
        err  = (!par && (syn != 7'd0)) || (par && (syn > 7'd71));
        data = corr ? (raw ^ flip) : raw;
    end

endmodule

module wr_fec_hamming_dec #(
    parameter int g_cnt_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    input  logic [15:0]            in_data_i,
    input  logic                   in_sof_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic [15:0]            out_data_o,
    input  logic                   out_ready_i,
    output logic                   out_corr_o,
    output logic                   out_err_o,
    input  logic                   cnt_clr_i,
    output logic [g_cnt_width-1:0] cnt_corr_o,
    output logic [g_cnt_width-1:0] cnt_uncorr_o
);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DECODE,
        ST_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [143:0] blk;
    logic [3:0]   wcnt;
    logic [2:0]   oidx;
    logic         in_take;
    logic         out_hs;

    logic [63:0]  dec_a, dec_b;
    logic         dec_corr_a, dec_err_a, dec_corr_b, dec_err_b;
    logic [63:0]  data_a_q, data_b_q;
    logic         corr_a_q, err_a_q, corr_b_q, err_b_q;

    logic [g_cnt_width-1:0] cnt_corr_q, cnt_uncorr_q;
    logic [1:0]             inc_corr, inc_uncorr;
    logic [g_cnt_width:0]   sum_corr, sum_uncorr;
    logic [63:0]            sel_data;

    wr_fec_hamming_cw_dec u_dec_a (
        .cw   (blk[71:0]),
        .data (dec_a),
        .corr (dec_corr_a),
        .err  (dec_err_a)
    );

    wr_fec_hamming_cw_dec u_dec_b (
        .cw   (blk[143:72]),
        .data (dec_b),
        .corr (dec_corr_b),
        .err  (dec_err_b)
    );

    assign in_take = in_valid_i && (state == ST_COLLECT);
    assign out_hs  = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            ST_COLLECT: begin
                in_ready_o = 1'b1;
                if (in_take && !in_sof_i && (wcnt == 4'd8)) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i && (oidx == 3'd7)) begin
                    state_nxt = ST_COLLECT;
                end
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase
    end

    // A start-of-frame word always lands in slot 0; stale words of an abandoned block get overwritten.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blk      <= '0;
            wcnt     <= '0;
            oidx     <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            corr_a_q <= 1'b0;
            err_a_q  <= 1'b0;
            corr_b_q <= 1'b0;
            err_b_q  <= 1'b0;
        end else begin
            if (in_take) begin
                if (in_sof_i) begin
                    blk[15:0] <= in_data_i;
                    wcnt      <= 4'd1;
                end else begin
                    for (int n = 0; n < 9; n++) begin
                        if (wcnt == 4'(n)) begin
                            blk[16*n +: 16] <= in_data_i;
                        end
                    end
                    wcnt <= (wcnt == 4'd8) ? 4'd0 : wcnt + 4'd1;
                end
            end
            if (state == ST_DECODE) begin
                data_a_q <= dec_a;
                data_b_q <= dec_b;
                corr_a_q <= dec_corr_a;
                err_a_q  <= dec_err_a;
                corr_b_q <= dec_corr_b;
                err_b_q  <= dec_err_b;
                oidx     <= 3'd0;
            end else if (out_hs) begin
                oidx <= oidx + 3'd1;
            end
        end
    end

    assign inc_corr   = {1'b0, dec_corr_a} + {1'b0, dec_corr_b};
    assign inc_uncorr = {1'b0, dec_err_a} + {1'b0, dec_err_b};
    assign sum_corr   = {1'b0, cnt_corr_q} + {{(g_cnt_width-1){1'b0}}, inc_corr};
    assign sum_uncorr = {1'b0, cnt_uncorr_q} + {{(g_cnt_width-1){1'b0}}, inc_uncorr};

    // Clear has priority over the DECODE-cycle increment; a carry out means saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clr_i) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else if (state == ST_DECODE) begin
            cnt_corr_q   <= sum_corr[g_cnt_width] ? '1 : sum_corr[g_cnt_width-1:0];
            cnt_uncorr_q <= sum_uncorr[g_cnt_width] ? '1 : sum_uncorr[g_cnt_width-1:0];
        end
    end

    assign cnt_corr_o   = cnt_corr_q;
    assign cnt_uncorr_o = cnt_uncorr_q;

    always_comb begin
        sel_data   = oidx[2] ? data_b_q : data_a_q;
        out_corr_o = oidx[2] ? corr_b_q : corr_a_q;
        out_err_o  = oidx[2] ? err_b_q : err_a_q;
        case (oidx[1:0])
            2'd0:    out_data_o = sel_data[15:0];
            2'd1:    out_data_o = sel_data[31:16];
            2'd2:    out_data_o = sel_data[47:32];
            default: out_data_o = sel_data[63:48];
        endcase
    end

endmodule

// File: doc/wr_fec_hamming_dec.md
# wr_fec_hamming_dec

Receive-side SEC-DED decoder for the WR FEC path; it is the counterpart of the encoder inside `wr_fec_engine`. It takes the 16-bit encoded payload stream that follows the Ethernet and FEC headers and collects it into 144-bit blocks. Each block holds two Hamming(72,64) codewords. The block corrects single-bit errors, flags uncorrectable ones, and emits the 8 recovered 16-bit data words per block toward the FEC reassembly logic.

## Interface
- `g_cnt_width`, default 16: width of the saturating error counters.
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `in_valid_i`, in, 1: input word valid.
- `in_data_i`, in, 16: encoded payload word.
- `in_sof_i`, in, 1: qualifies the first word of a payload. It restarts block assembly.
- `in_ready_o`, out, 1: decoder accepts a word this cycle.
- `out_valid_o`, out, 1: decoded data word valid.
- `out_data_o`, out, 16: decoded data word.
- `out_ready_i`, in, 1: downstream takes the word.
- `out_corr_o`, out, 1: the codeword containing this word had a single-bit error, which has been corrected.
- `out_err_o`, out, 1: the codeword containing this word is uncorrectable. Data is passed through raw.
- `cnt_clr_i`, in, 1: clear both counters.
- `cnt_corr_o`, out, `g_cnt_width`: corrected-codeword count, saturating.
- `cnt_uncorr_o`, out, `g_cnt_width`: uncorrectable-codeword count, saturating.

## Operation
- **Block assembly**
  - Input word n (0..8) occupies block bits [16n+15:16n].
  - Codeword A is block[71:0]; codeword B is block[143:72].
- **Codeword layout** (c[0..71])
  - c[0] is the overall parity.
  - c[1], c[2], c[4], c[8], c[16], c[32], c[64] are the Hamming parity bits.
  - Data d[0..63] occupies the remaining positions in ascending order (d[0]=c[3], d[1]=c[5], …, d[63]=c[71]).
- **Syndrome**
  - s[k] = XOR of c[i] for i in 1..71 where bit k of i is set, k = 0..6.
  - p = XOR of c[0..71].
- **Decode rules**
  - s=0, p=0: clean.
  - p=1 and s≤71: flip c[s] (s=0 flips c[0]). Mark corrected.
  - p=0 and s≠0: uncorrectable.
  - p=1 and s>71: uncorrectable.
- **Output**
  - Output word j of a codeword is d[16j+15:16j].
  - Output order is A0, A1, A2, A3, B0, B1, B2, B3.
  - `out_corr_o` and `out_err_o` are constant across a codeword's 4 words.
- **FSM**
  - COLLECT:
    - `in_ready_o`=1.
    - Each accepted word increments the word counter (0..8).
    - Accepting word 8 moves to DECODE.
  - DECODE:
    - One cycle.
    - Registers corrected data, flags and counter increments for A and B.
    - Moves to OUTPUT.
  - OUTPUT:
    - `out_valid_o`=1.
    - Each `out_valid_o`&`out_ready_i` advances the output index (0..7).
    - The handshake on index 7 returns to COLLECT with the word counter at 0.
- **`in_sof_i` handling**
  - Accepted with `in_valid_i` in COLLECT: any partial block is discarded, and that word is stored as word 0 (counter then 1).
  - In other states: `in_ready_o`=0, so it is not sampled.
- **Counters**
  - Each counter increments once per codeword, so by 0, 1 or 2 per block, in the DECODE cycle.
  - Counters saturate at all-ones.
  - `cnt_clr_i` wins over a simultaneous increment.

## Timing
- **Reset values**: all outputs 0, except `in_ready_o`=1 from the first cycle after reset deasserts. The FSM is in COLLECT and both counters are 0.
- **Reset mid-block**: the partial input and pending output are dropped. There are no spurious `out_valid_o` pulses.
- **Latency**: word 8 is accepted in cycle t. DECODE is cycle t+1. `out_valid_o` is first high in cycle t+2 with A0.
- **Throughput**: with `out_ready_i`=1, one block per 18 cycles (9 collect, 1 decode, 8 output).
- **Output hold**: `out_data_o`, `out_corr_o` and `out_err_o` stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- **Input backpressure**: no input is accepted during DECODE or OUTPUT.
- **Counter update**: counter outputs update in the cycle after DECODE, i.e. cycle t+2.

## Test plan
- **Clean block**: data 0x1100, 0x3322, 0x5544, 0x7766 (A) and 0x9988, 0xBBAA, 0xDDCC, 0xFFEE (B), encoded by the reference model → the same 8 words in order. Corr and err stay 0. First valid at t+2.
- **Single data-bit error**: flip c[5] of A (d[1]) → A0 reads 0x1100, `out_corr_o`=1 on words A0–A3 only, and `cnt_corr_o`=1. Repeat with c[0] flipped in B → B data is unchanged and B is flagged corrected.
- **Double error**: flip c[3] and c[6] in B → `out_err_o`=1 on B0–B3, `cnt_uncorr_o`=1, and A is untouched.
- **Backpressure**: toggle `out_ready_i` at 50% → each word is held stable until taken, exactly 8 handshakes occur, and `in_ready_o` stays 0 until the last one.
- **Restart and reset**:
  - Send 4 words, then assert `in_sof_i` with a new clean block → only the new block is decoded.
  - Assert `rst_i` during OUTPUT index 3 → `out_valid_o`=0 next cycle, counters are 0, `in_ready_o`=1.
- **Saturation and clear**:
  - With `g_cnt_width`=2, send 5 blocks each with a single error in A → `cnt_corr_o` reaches 3 and holds.
  - Assert `cnt_clr_i` in the same cycle as an increment → counter reads 0.
